// File: rtl/m_mem_ctrl_pkg.sv
// Shared encodings for the M-stage memory controller: load/store types,
// exception codes, FSM states and the alignment check.
package m_mem_ctrl_pkg;

    localparam logic [2:0] DM_lw  = 3'd0;
    localparam logic [2:0] DM_lh  = 3'd1;
    localparam logic [2:0] DM_lhu = 3'd2;
    localparam logic [2:0] DM_lb  = 3'd3;
    localparam logic [2:0] DM_lbu = 3'd4;

    localparam logic [1:0] ST_sw = 2'd0;
    localparam logic [1:0] ST_sh = 2'd1;
    localparam logic [1:0] ST_sb = 2'd2;

    localparam logic [4:0] EXC_AdEL = 5'd4;
    localparam logic [4:0] EXC_AdES = 5'd5;
    localparam logic [4:0] EXC_DBE  = 5'd7;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    // Word accesses need addr[1:0]=0, halfwords addr[0]=0, bytes never trap.
    function automatic logic f_misaligned(input logic       i_we,
                                          input logic [1:0] i_addr_lo,
                                          input logic [1:0] i_st_type,
                                          input logic [2:0] i_ld_type);
        logic w_mis;
        w_mis = 1'b0;
        if (i_we) begin
            case (i_st_type)
                ST_sw:   w_mis = |i_addr_lo;
                ST_sh:   w_mis = i_addr_lo[0];
                default: w_mis = 1'b0;
            endcase
        end else begin
            case (i_ld_type)
                DM_lw:         w_mis = |i_addr_lo;
                DM_lh, DM_lhu: w_mis = i_addr_lo[0];
                default:       w_mis = 1'b0;
            endcase
        end
        return w_mis;
    endfunction

endpackage

// File: rtl/m_mem_ctrl_if.sv
// Pipeline request, data-bus, load-result and exception signals of the
// M-stage memory controller.
interface m_mem_ctrl_if;

    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_store_type;
    logic [2:0]  req_load_type;
    logic        flush;
    logic        stall;

    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_byteen;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    logic        rd_valid;
    logic [31:0] rd_data;
    logic [1:0]  rd_addr_lo;
    logic [2:0]  rd_load_type;

    logic        exc_valid;
    logic [4:0]  exc_code;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_store_type,
               req_load_type, flush, bus_ack, bus_rdata,
        output stall, bus_req, bus_we, bus_addr, bus_byteen, bus_wdata,
               rd_valid, rd_data, rd_addr_lo, rd_load_type, exc_valid, exc_code
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_store_type,
               req_load_type, flush, bus_ack, bus_rdata,
        input  stall, bus_req, bus_we, bus_addr, bus_byteen, bus_wdata,
               rd_valid, rd_data, rd_addr_lo, rd_load_type, exc_valid, exc_code
    );

endinterface

// File: rtl/m_store_align.sv
// Store lane steering: byte enables and replicated write data from the
// low address bits and the store type.
module m_store_align
    import m_mem_ctrl_pkg::*;
(
    input  logic [1:0]  i_addr_lo,
    input  logic [1:0]  i_st_type,
    input  logic [31:0] i_wdata,
    output logic [3:0]  o_byteen,
    output logic [31:0] o_wdata
);

    always_comb begin
        o_byteen = 4'b1111;
        o_wdata  = i_wdata;
        case (i_st_type)
            ST_sh: begin
                o_byteen = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata  = {2{i_wdata[15:0]}};
            end
            ST_sb: begin
                o_byteen = 4'b0001 << i_addr_lo;
                o_wdata  = {4{i_wdata[7:0]}};
            end
            default: begin
                o_byteen = 4'b1111;
                o_wdata  = i_wdata;
            end
        endcase
    end

endmodule

// File: rtl/m_mem_ctrl.sv
// M-stage data-memory controller: one req/ack bus transaction per load/store,
// pipeline stall while it runs, alignment and bus-timeout exceptions.
module m_mem_ctrl
    import m_mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset,
    m_mem_ctrl_if.slave   mif
);

    localparam logic [7:0] TO_M1 = 8'(TIMEOUT - 1);

    logic [1:0]  r_state;
    logic [7:0]  r_cnt;
    logic        r_drop;
    logic        r_bus_req;
    logic        r_bus_we;
    logic [31:0] r_bus_addr;
    logic [3:0]  r_bus_byteen;
    logic [31:0] r_bus_wdata;
    logic [1:0]  r_addr_lo;
    logic [2:0]  r_load_type;
    logic        r_rd_valid;
    logic [31:0] r_rd_data;
    logic [1:0]  r_rd_addr_lo;
    logic [2:0]  r_rd_load_type;

    logic        w_misal;
    logic        w_accept;
    logic        w_keep;
    logic [3:0]  w_byteen;
    logic [31:0] w_wdata;

    m_store_align u_store_align (
        .i_addr_lo (mif.req_addr[1:0]),
        .i_st_type (mif.req_store_type),
        .i_wdata   (mif.req_wdata),
        .o_byteen  (w_byteen),
        .o_wdata   (w_wdata)
    );

    assign w_misal  = f_misaligned(mif.req_we, mif.req_addr[1:0],
                                   mif.req_store_type, mif.req_load_type);
    assign w_accept = (r_state == S_IDLE) && mif.req_valid && !mif.flush && !w_misal;
    // A flush arriving in the ack cycle must still squash the result.
    assign w_keep   = !(r_drop || mif.flush);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_drop         <= 1'b0;
            r_bus_req      <= 1'b0;
            r_bus_we       <= 1'b0;
            r_bus_addr     <= '0;
            r_bus_byteen   <= '0;
            r_bus_wdata    <= '0;
            r_addr_lo      <= '0;
            r_load_type    <= '0;
            r_rd_valid     <= 1'b0;
            r_rd_data      <= '0;
            r_rd_addr_lo   <= '0;
            r_rd_load_type <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt  <= '0;
                    r_drop <= 1'b0;
                    if (w_accept) begin
                        r_bus_req    <= 1'b1;
                        r_bus_we     <= mif.req_we;
                        r_bus_addr   <= {mif.req_addr[31:2], 2'b00};
                        r_bus_byteen <= mif.req_we ? w_byteen : 4'b0000;
                        r_bus_wdata  <= mif.req_we ? w_wdata : 32'd0;
                        r_addr_lo    <= mif.req_addr[1:0];
                        r_load_type  <= mif.req_load_type;
                        r_state      <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_cnt <= r_cnt + 8'd1;
                    if (mif.flush)
                        r_drop <= 1'b1;
                    if (mif.bus_ack) begin
                        r_bus_req <= 1'b0;
                        r_state   <= S_DONE;
                        if (!r_bus_we && w_keep) begin
                            r_rd_valid     <= 1'b1;
                            r_rd_data      <= mif.bus_rdata;
                            r_rd_addr_lo   <= r_addr_lo;
                            r_rd_load_type <= r_load_type;
                        end
                    end else if (r_cnt == TO_M1) begin
                        r_bus_req <= 1'b0;
                        r_state   <= S_ERR;
                    end
                end
                S_DONE: begin
                    r_rd_valid <= 1'b0;
                    r_drop     <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_drop  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        mif.stall     = 1'b0;
        mif.exc_valid = 1'b0;
        mif.exc_code  = 5'd0;
        case (r_state)
            S_IDLE: begin
                if (mif.req_valid && !mif.flush) begin
                    if (w_misal) begin
                        mif.exc_valid = 1'b1;
                        mif.exc_code  = mif.req_we ? EXC_AdES : EXC_AdEL;
                    end else begin
                        mif.stall = 1'b1;
                    end
                end
            end
            S_BUSY: mif.stall = 1'b1;
            S_ERR: begin
                if (!r_drop) begin
                    mif.exc_valid = 1'b1;
                    mif.exc_code  = EXC_DBE;
                end
            end
            default: ;
        endcase
    end

    assign mif.bus_req      = r_bus_req;
    assign mif.bus_we       = r_bus_we;
    assign mif.bus_addr     = r_bus_addr;
    assign mif.bus_byteen   = r_bus_byteen;
    assign mif.bus_wdata    = r_bus_wdata;
    assign mif.rd_valid     = r_rd_valid;
    assign mif.rd_data      = r_rd_data;
    assign mif.rd_addr_lo   = r_rd_addr_lo;
    assign mif.rd_load_type = r_rd_load_type;

endmodule

// File: tb/tb_m_mem_ctrl.sv
// Directed bench for m_mem_ctrl: loads, stores, alignment traps, bus timeout,
// flush squash and mid-transaction reset.
module tb_m_mem_ctrl;
    import m_mem_ctrl_pkg::*;

    logic clk;
    logic reset;
    int   n_tot;
    int   n_bad;

    // Per-access observations accumulated at each falling edge.
    int          s_stall, s_breq, s_rdv, s_exc;
    logic [4:0]  s_code;
    logic [3:0]  s_be;
    logic [31:0] s_wd, s_ba;
    logic        s_bwe;

    m_mem_ctrl_if mif();

    m_mem_ctrl #(.TIMEOUT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .mif   (mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    // Issue one access starting at posedge+1; ack arrives in BUSY cycle ack_at
    // (0 = never), flush pulses in cycle flush_at (0 = none). Runs 10 cycles.
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] st, input logic [2:0] lt,
                          input int ack_at, input logic [31:0] rdata, input int flush_at);
        logic st_seen;
        s_stall = 0; s_breq = 0; s_rdv = 0; s_exc = 0;
        s_code = '0; s_be = '0; s_wd = '0; s_ba = '0; s_bwe = 1'b0;
        mif.req_valid      = 1'b1;
        mif.req_we         = we;
        mif.req_addr       = addr;
        mif.req_wdata      = wdata;
        mif.req_store_type = st;
        mif.req_load_type  = lt;
        mif.bus_rdata      = rdata;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            st_seen = mif.stall;
            if (mif.stall)     s_stall++;
            if (mif.rd_valid)  s_rdv++;
            if (mif.exc_valid) begin s_exc++; s_code = mif.exc_code; end
            if (mif.bus_req) begin
                s_breq++;
                s_be = mif.bus_byteen; s_wd = mif.bus_wdata;
                s_ba = mif.bus_addr;   s_bwe = mif.bus_we;
            end
            @(posedge clk); #1;
            if (!st_seen) mif.req_valid = 1'b0;
            mif.bus_ack = (ack_at != 0) && (cyc + 1 == ack_at);
            mif.flush   = (flush_at != 0) && (cyc + 1 == flush_at);
        end
        mif.bus_ack = 1'b0;
        mif.flush   = 1'b0;
    endtask

    initial begin
        n_tot = 0; n_bad = 0;
        reset = 1'b0;
        mif.req_valid = 1'b0; mif.req_we = 1'b0; mif.req_addr = '0; mif.req_wdata = '0;
        mif.req_store_type = ST_sw; mif.req_load_type = DM_lw; mif.flush = 1'b0;
        mif.bus_ack = 1'b0; mif.bus_rdata = '0;

        repeat (2) @(negedge clk);
        chk("rst_stall", mif.stall, 0);
        chk("rst_breq",  mif.bus_req, 0);
        chk("rst_baddr", mif.bus_addr, 0);
        chk("rst_rdv",   mif.rd_valid, 0);
        chk("rst_exc",   mif.exc_valid, 0);
        @(posedge clk); #1 reset = 1'b1;

        access(1'b0, 32'h10, 0, ST_sw, DM_lw, 1, 32'hDEADBEEF, 0);
        chk("lw_stall", s_stall, 2);
        chk("lw_breq",  s_breq, 1);
        chk("lw_baddr", s_ba, 32'h10);
        chk("lw_be",    s_be, 4'b0000);
        chk("lw_bwe",   s_bwe, 0);
        chk("lw_rdv",   s_rdv, 1);
        chk("lw_exc",   s_exc, 0);
        chk("lw_rdata", mif.rd_data, 32'hDEADBEEF);
        chk("lw_lo",    mif.rd_addr_lo, 0);
        chk("lw_type",  mif.rd_load_type, DM_lw);

        access(1'b1, 32'h3, 32'hA5, ST_sb, DM_lw, 2, 32'h0, 0);
        chk("sb_stall", s_stall, 3);
        chk("sb_be",    s_be, 4'b1000);
        chk("sb_wd",    s_wd, 32'hA5A5A5A5);
        chk("sb_baddr", s_ba, 32'h0);
        chk("sb_bwe",   s_bwe, 1);
        chk("sb_rdv",   s_rdv, 0);
        chk("sb_hold",  mif.rd_data, 32'hDEADBEEF);

        access(1'b1, 32'h102, 32'hFFFF1234, ST_sh, DM_lw, 1, 32'h0, 0);
        chk("sh_be",    s_be, 4'b1100);
        chk("sh_wd",    s_wd, 32'h12341234);
        chk("sh_baddr", s_ba, 32'h100);

        access(1'b1, 32'h8, 32'h01234567, ST_sw, DM_lw, 1, 32'h0, 0);
        chk("sw_be",    s_be, 4'b1111);
        chk("sw_wd",    s_wd, 32'h01234567);

        access(1'b0, 32'h1, 0, ST_sw, DM_lh, 1, 32'h0, 0);
        chk("lh_mis_exc",   s_exc, 1);
        chk("lh_mis_code",  s_code, 4);
        chk("lh_mis_breq",  s_breq, 0);
        chk("lh_mis_stall", s_stall, 0);

        access(1'b1, 32'h2, 32'h55, ST_sw, DM_lw, 1, 32'h0, 0);
        chk("sw_mis_exc",  s_exc, 1);
        chk("sw_mis_code", s_code, 5);
        chk("sw_mis_breq", s_breq, 0);

        access(1'b0, 32'h2, 0, ST_sw, DM_lw, 1, 32'h0, 0);
        chk("lw_mis_code", s_code, 4);

        access(1'b0, 32'h7, 0, ST_sw, DM_lb, 3, 32'h11223344, 0);
        chk("lb_stall", s_stall, 4);
        chk("lb_breq",  s_breq, 3);
        chk("lb_baddr", s_ba, 32'h4);
        chk("lb_rdv",   s_rdv, 1);
        chk("lb_rdata", mif.rd_data, 32'h11223344);
        chk("lb_lo",    mif.rd_addr_lo, 3);
        chk("lb_type",  mif.rd_load_type, DM_lb);

        access(1'b0, 32'h20, 0, ST_sw, DM_lw, 0, 32'h0, 0);
        chk("to_breq",  s_breq, 4);
        chk("to_stall", s_stall, 5);
        chk("to_exc",   s_exc, 1);
        chk("to_code",  s_code, 7);
        chk("to_rdv",   s_rdv, 0);

        access(1'b0, 32'h30, 0, ST_sw, DM_lw, 3, 32'h99999999, 1);
        chk("fl_breq",  s_breq, 3);
        chk("fl_rdv",   s_rdv, 0);
        chk("fl_exc",   s_exc, 0);

        access(1'b0, 32'h44, 0, ST_sw, DM_lhu, 1, 32'hCAFEF00D, 0);
        chk("post_fl_rdv",   s_rdv, 1);
        chk("post_fl_rdata", mif.rd_data, 32'hCAFEF00D);
        chk("post_fl_type",  mif.rd_load_type, DM_lhu);

        access(1'b0, 32'h60, 0, ST_sw, DM_lw, 0, 32'h0, 2);
        chk("flto_breq", s_breq, 4);
        chk("flto_exc",  s_exc, 0);

        // Asynchronous reset in the middle of a BUSY transaction.
        mif.req_valid = 1'b1; mif.req_we = 1'b0; mif.req_addr = 32'h50;
        mif.req_load_type = DM_lw; mif.bus_rdata = 32'h77777777;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        chk("mr_breq_pre", mif.bus_req, 1);
        #1 reset = 1'b0; mif.req_valid = 1'b0;
        #1;
        chk("mr_breq",  mif.bus_req, 0);
        chk("mr_stall", mif.stall, 0);
        chk("mr_baddr", mif.bus_addr, 0);
        chk("mr_rdata", mif.rd_data, 0);
        chk("mr_exc",   mif.exc_valid, 0);
        @(posedge clk); #1 reset = 1'b1; mif.bus_ack = 1'b1;
        s_rdv = 0; s_breq = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (mif.rd_valid) s_rdv++;
            if (mif.bus_req)  s_breq++;
            @(posedge clk); #1 mif.bus_ack = 1'b0;
        end
        chk("mr_late_rdv",  s_rdv, 0);
        chk("mr_late_breq", s_breq, 0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule

// File: doc/m_mem_ctrl.md
# m_mem_ctrl

M-stage data-memory access controller. Accepts one load/store per instruction from the M pipeline register and runs a variable-latency request/acknowledge transaction on the data bus. It stalls the pipeline until the transaction finishes, flags alignment and bus-timeout exceptions, and hands the raw read word, low address bits and load type to the downstream load-extension stage.

## Interface
- `TIMEOUT`, 255: max BUSY cycles without `bus_ack` before a bus-error exception; 1..255.
- `clk` in 1: sole clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low.
- `req_valid` in 1: M-stage instruction accesses memory.
- `req_we` in 1: 1 = store, 0 = load.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `req_store_type` in 2: `ST_sw`/`ST_sh`/`ST_sb`.
- `req_load_type` in 3: `DM_lw`/`DM_lh`/`DM_lhu`/`DM_lb`/`DM_lbu` (shared encoding).
- `flush` in 1: CP0 exception/eret flush of M stage.
- `stall` out 1: freeze F/D/E/M.
- `bus_req` out 1, `bus_we` out 1, `bus_addr` out 32 (word-aligned, [1:0]=0), `bus_byteen` out 4, `bus_wdata` out 32.
- `bus_ack` in 1, `bus_rdata` in 32.
- `rd_valid` out 1: load result valid this cycle.
- `rd_data` out 32: raw bus word.
- `rd_addr_lo` out 2: req_addr[1:0] of the load.
- `rd_load_type` out 3: load type of the load.
- `exc_valid` out 1, `exc_code` out 5: 4 = AdEL, 5 = AdES, 7 = DBE.

## Operation
- States: IDLE, BUSY, DONE, ERR. Reset → IDLE; all outputs 0, counter 0, drop flag 0.
- IDLE, `req_valid`=1, aligned, no `flush`: latch address/type/data/byte-enables, → BUSY; `stall`=1.
- Alignment: lw/sw need addr[1:0]=0; lh/lhu/sh need addr[0]=0; bytes always aligned. Misaligned in IDLE → `exc_valid`=1 same cycle (code 4 load, 5 store), no bus cycle, `stall`=0, stay IDLE.
- BUSY: `bus_req`=1; `bus_*` stable from latched values until ack. Counter increments each BUSY cycle.
  - `bus_ack`=1 → capture `bus_rdata`, → DONE.
  - Counter reaches `TIMEOUT` without ack → drop `bus_req`, → ERR.
- DONE: `stall`=0; `rd_valid`=1 for loads (0 for stores) unless drop flag set; → IDLE. `req_valid` is ignored in DONE because it is the same instruction.
- ERR: `exc_valid`=1, `exc_code`=7, `stall`=0; → IDLE.
- `flush` in IDLE: no request accepted. `flush` in BUSY: the bus cycle is not retracted. Set the drop flag; the transaction finishes normally, but DONE shows no `rd_valid` and ERR shows no `exc_valid`. The drop flag clears on IDLE entry.
- Byte enables and data:
  - sw: 1111, data as is.
  - sh: addr[1] ? 1100 : 0011, data {2{wdata[15:0]}}.
  - sb: 0001 << addr[1:0], data {4{wdata[7:0]}}.
  - Loads: byteen 0000.
- `rd_data`/`rd_addr_lo`/`rd_load_type` are registered and hold their values until the next load's DONE.

## Timing
- Minimum latency: request accepted at cycle 0, ack at cycle 1, DONE at cycle 2. The pipeline stalls for cycles 0–1 and advances at the end of cycle 2.
- For ack at BUSY cycle k, `stall` is high for k+1 cycles.
- Timeout: ERR is entered after `TIMEOUT` BUSY cycles.
- `stall`, `exc_valid` and `exc_code` are combinational from state and inputs. All other outputs are registered.
- Asynchronous reset mid-BUSY: immediate IDLE and `bus_req`=0. No response follows, and a late `bus_ack` is ignored.
- A `bus_ack` arriving outside BUSY is ignored.

## Structure
- Shared define file (with the existing `DM_*` load codes) gains `ST_sw`/`ST_sh`/`ST_sb`, `EXC_AdEL`/`EXC_AdES`/`EXC_DBE`, and the state encodings.
- One sub-module, `m_store_align`: combinational byte-enable and write-data replication from addr[1:0] and store type. The FSM, counter and alignment check live in `m_mem_ctrl`.

## Test plan
- lw at 0x0000_0010, `bus_ack` 1 cycle later with rdata 0xDEADBEEF → `stall` high for 2 cycles, then `rd_valid`=1, `rd_data`=0xDEADBEEF, `rd_addr_lo`=0.
- sb at 0x0000_0003, wdata 0x000000A5 → `bus_byteen`=1000, `bus_wdata`=0xA5A5A5A5, `rd_valid` stays 0.
- lh at 0x0000_0001 → `exc_valid`=1, `exc_code`=4, `bus_req` never high, `stall`=0. sw at 0x0000_0002 → code 5.
- `TIMEOUT`=4, no ack → `bus_req` high 4 cycles, then ERR: `exc_code`=7, `stall`=0.
- lw with `flush` pulsed during BUSY, ack after 3 cycles → transaction completes, `rd_valid` never asserted, next lw proceeds normally.
- `reset` low during BUSY, then ack arrives → IDLE immediately, all outputs 0, no `rd_valid`.
